// File: rtl/ped_crossing_sequencer.sv
// ped_crossing_sequencer
// Pedestrian-phase sequencer: follows the controller's vehicle-red phase and
// runs WALK -> FLASH (countdown) -> CLEAR, driving the pedestrian lamps, the
// wait indicator and the countdown digit / enable for the 7-segment driver.
// Optional accessibility tone gate on ped_beep when PED_BEEP_EN is defined.
module ped_crossing_sequencer #(
    parameter int unsigned T_WALK   = 12,
    parameter int unsigned T_FLASH  = 8,
    parameter logic [2:0]  RED_CODE = 3'd1
) (
    input  logic       clk_1Hz,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [2:0] ctrl_state,
    input  logic       ped_req,
    output logic       ped_green,
    output logic       ped_red,
    output logic       ped_wait,
    output logic [3:0] digit,
    output logic       display_active,
    output logic       walk_done
`ifdef PED_BEEP_EN
    ,
    output logic       ped_beep
`endif
);

    typedef enum logic [2:0] {
        S_OFF,
        S_DONT_WALK,
        S_WALK,
        S_FLASH,
        S_CLEAR
    } state_t;

    state_t     r_state, w_state_nx;
    logic [4:0] r_tmr,   w_tmr_nx;
    logic [3:0] r_cnt,   w_cnt_nx;
    logic       r_blink, w_blink_nx;
    logic       r_wait,  w_wait_nx;
    logic       r_red_d;
    logic       w_is_red;
    logic       w_red_rise;

    assign w_is_red   = (ctrl_state == RED_CODE);
    assign w_red_rise = w_is_red && !r_red_d;

    // State, counters, red history and wait latch registers
    always_ff @(posedge clk_1Hz) begin
        if (!rst_n) begin
            r_state <= S_OFF;
            r_tmr   <= '0;
            r_cnt   <= '0;
            r_blink <= 1'b0;
            r_wait  <= 1'b0;
            r_red_d <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_tmr   <= w_tmr_nx;
            r_cnt   <= w_cnt_nx;
            r_blink <= w_blink_nx;
            r_wait  <= w_wait_nx;
            r_red_d <= w_is_red;
        end
    end

    // Next-state logic and output decode from the registered state
    always_comb begin
        w_state_nx     = r_state;
        w_tmr_nx       = r_tmr;
        w_cnt_nx       = r_cnt;
        w_blink_nx     = r_blink;
        w_wait_nx      = r_wait;
        ped_green      = 1'b0;
        ped_red        = 1'b0;
        ped_wait       = 1'b0;
        digit          = '0;
        display_active = 1'b0;
        walk_done      = 1'b0;

        case (r_state)
            S_OFF: begin
            end
            S_DONT_WALK: begin
                ped_red  = 1'b1;
                ped_wait = r_wait;
            end
            S_WALK: begin
                ped_green = 1'b1;
            end
            S_FLASH: begin
                ped_green      = r_blink;
                display_active = 1'b1;
                digit          = r_cnt;
            end
            S_CLEAR: begin
                ped_red   = 1'b1;
                walk_done = 1'b1;
            end
            default: begin
            end
        endcase

        if (!enable) begin
            w_state_nx = S_OFF;
            w_tmr_nx   = '0;
            w_cnt_nx   = '0;
            w_blink_nx = 1'b0;
            w_wait_nx  = 1'b0;
        end else begin
            case (r_state)
                S_OFF: begin
                    w_state_nx = S_DONT_WALK;
                end
                S_DONT_WALK: begin
                    // A red entry clears the latch even if a request arrives at the same edge
                    if (w_red_rise) begin
                        w_state_nx = S_WALK;
                        w_tmr_nx   = '0;
                        w_wait_nx  = 1'b0;
                    end else if (ped_req) begin
                        w_wait_nx = 1'b1;
                    end
                end
                S_WALK: begin
                    if (!w_is_red) begin
                        w_state_nx = S_CLEAR;
                    end else if (r_tmr == 5'(T_WALK - 1)) begin
                        w_state_nx = S_FLASH;
                        w_cnt_nx   = 4'(T_FLASH - 1);
                        w_blink_nx = 1'b1;
                    end else begin
                        w_tmr_nx = r_tmr + 5'd1;
                    end
                end
                S_FLASH: begin
                    if (!w_is_red || r_cnt == 4'd0) begin
                        w_state_nx = S_CLEAR;
                    end else begin
                        w_cnt_nx   = r_cnt - 4'd1;
                        w_blink_nx = !r_blink;
                    end
                end
                S_CLEAR: begin
                    w_state_nx = S_DONT_WALK;
                end
                default: begin
                    w_state_nx = S_OFF;
                end
            endcase
        end
    end

`ifdef PED_BEEP_EN
    assign ped_beep = (r_state == S_WALK) || ((r_state == S_FLASH) && r_blink);
`endif

endmodule

// File: tb/tb_ped_crossing_sequencer.sv
// tb_ped_crossing_sequencer
// Directed scenarios plus randomized traffic for ped_crossing_sequencer, each
// cycle compared against an elapsed-time model of the pedestrian crossing.
// Build with +define+PED_BEEP_EN to also cover the ped_beep output.
module tb_ped_crossing_sequencer;

    localparam int T_WALK  = 12;
    localparam int T_FLASH = 8;

    logic       clk_1Hz = 1'b0;
    logic       rst_n   = 1'b0;
    logic       enable  = 1'b0;
    logic [2:0] ctrl_state = 3'd0;
    logic       ped_req = 1'b0;
    logic       ped_green, ped_red, ped_wait, display_active, walk_done;
    logic [3:0] digit;
    logic       beep_obs;

    int n_checks = 0;
    int n_err    = 0;

    // Model: crossing tracked as elapsed cycles since the walk started
    bit m_on, m_clear, m_wait, m_prev_red;
    int m_age = -1;

    ped_crossing_sequencer #(
        .T_WALK  (T_WALK),
        .T_FLASH (T_FLASH),
        .RED_CODE(3'd1)
    ) dut (
        .clk_1Hz       (clk_1Hz),
        .rst_n         (rst_n),
        .enable        (enable),
        .ctrl_state    (ctrl_state),
        .ped_req       (ped_req),
        .ped_green     (ped_green),
        .ped_red       (ped_red),
        .ped_wait      (ped_wait),
        .digit         (digit),
        .display_active(display_active),
        .walk_done     (walk_done)
`ifdef PED_BEEP_EN
        ,
        .ped_beep      (beep_obs)
`endif
    );

`ifndef PED_BEEP_EN
    assign beep_obs = 1'b0;
`endif

    always #5 clk_1Hz = ~clk_1Hz;

    logic [9:0] w_obs;
    assign w_obs = {ped_green, ped_red, ped_wait, digit, display_active, walk_done, beep_obs};

    function automatic logic [9:0] exp_vec();
        logic g, r, w, da, wd, b;
        logic [3:0] d;
        int k;
        g = 0; r = 0; w = 0; da = 0; wd = 0; b = 0; d = 4'd0;
        if (!m_on) begin
        end else if (m_clear) begin
            r = 1; wd = 1;
        end else if (m_age >= 0 && m_age < T_WALK) begin
            g = 1; b = 1;
        end else if (m_age >= T_WALK) begin
            k  = m_age - T_WALK;
            g  = (k % 2 == 0);
            d  = 4'(T_FLASH - 1 - k);
            da = 1;
            b  = g;
        end else begin
            r = 1; w = m_wait;
        end
`ifndef PED_BEEP_EN
        b = 0;
`endif
        return {g, r, w, d, da, wd, b};
    endfunction

    task automatic step(input bit rst, input bit en, input logic [2:0] ctrl, input bit req);
        bit red, rise;
        rst_n = rst; enable = en; ctrl_state = ctrl; ped_req = req;
        @(posedge clk_1Hz);
        red = (ctrl == 3'd1);
        if (!rst) begin
            m_on = 0; m_age = -1; m_clear = 0; m_wait = 0; m_prev_red = 0;
        end else begin
            rise = red && !m_prev_red;
            if (!en) begin
                m_on = 0; m_age = -1; m_clear = 0; m_wait = 0;
            end else if (!m_on) begin
                m_on = 1;
            end else if (m_clear) begin
                m_clear = 0;
            end else if (m_age >= 0) begin
                if (!red || m_age == T_WALK + T_FLASH - 1) begin
                    m_age = -1; m_clear = 1;
                end else begin
                    m_age++;
                end
            end else if (rise) begin
                m_age = 0; m_wait = 0;
            end else if (req) begin
                m_wait = 1;
            end
            m_prev_red = red;
        end
        #1;
    endtask

    task automatic test_reset();
        step(0, 1, 3'd1, 1);
        n_checks++;
        if (w_obs !== 10'd0) begin
            n_err++; $display("FAIL reset got=%b want=%b", w_obs, 10'd0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 3'd0, 0);
            n_checks++;
            if (w_obs !== exp_vec()) begin
                n_err++; $display("FAIL reset_to_dw cyc=%0d got=%b want=%b", i, w_obs, exp_vec());
            end
        end
        n_checks++;
        if ({ped_red, ped_green, digit, display_active} !== 7'b1000000) begin
            n_err++; $display("FAIL dw_outputs got=%b want=%b", {ped_red, ped_green, digit, display_active}, 7'b1000000);
        end
    endtask

    task automatic test_walk_sequence();
        int greens = 0;
        for (int i = 0; i < 25; i++) begin
            step(1, 1, 3'd1, 0);
            if (i < T_WALK) greens += int'(ped_green);
            n_checks++;
            if (w_obs !== exp_vec()) begin
                n_err++; $display("FAIL walk_seq cyc=%0d got=%b want=%b", i, w_obs, exp_vec());
            end
        end
        n_checks++;
        if (greens !== T_WALK) begin
            n_err++; $display("FAIL walk_len got=%0d want=%0d", greens, T_WALK);
        end
    endtask

    task automatic test_wait_latch();
        logic [2:0] c [8] = '{3'd3, 3'd3, 3'd3, 3'd1, 3'd3, 3'd3, 3'd3, 3'd1};
        bit         q [8] = '{0, 1, 0, 0, 0, 0, 0, 1};
        for (int i = 0; i < 8; i++) begin
            step(1, 1, c[i], q[i]);
            n_checks++;
            if (w_obs !== exp_vec()) begin
                n_err++; $display("FAIL wait_latch cyc=%0d got=%b want=%b", i, w_obs, exp_vec());
            end
        end
        // requests during the walk are not latched
        step(1, 1, 3'd1, 1);
        step(1, 1, 3'd3, 1);
        step(1, 1, 3'd3, 0);
        step(1, 1, 3'd3, 0);
        n_checks++;
        if (ped_wait !== 1'b0 || w_obs !== exp_vec()) begin
            n_err++; $display("FAIL wait_ignored got=%b want=%b", w_obs, exp_vec());
        end
    endtask

    task automatic test_abort();
        step(1, 1, 3'd1, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 3'd1, 0);
        step(1, 1, 3'd3, 0);
        n_checks++;
        if (walk_done !== 1'b1 || w_obs !== exp_vec()) begin
            n_err++; $display("FAIL abort_walk got=%b want=%b", w_obs, exp_vec());
        end
        for (int i = 0; i < 3; i++) step(1, 1, 3'd3, 0);
        step(1, 1, 3'd1, 0);
        for (int i = 0; i < T_WALK + 3; i++) step(1, 1, 3'd1, 0);
        n_checks++;
        if (digit !== 4'd4 || display_active !== 1'b1) begin
            n_err++; $display("FAIL flash_digit got=%0d want=4", digit);
        end
        for (int i = 0; i < 4; i++) begin
            step(1, 1, (i == 0) ? 3'd0 : 3'd1, 0);
            n_checks++;
            if (w_obs !== exp_vec()) begin
                n_err++; $display("FAIL abort_flash cyc=%0d got=%b want=%b", i, w_obs, exp_vec());
            end
        end
    endtask

    task automatic test_enable_drop();
        step(1, 1, 3'd0, 0);
        step(1, 1, 3'd1, 0);
        for (int i = 0; i < T_WALK + 2; i++) step(1, 1, 3'd1, 0);
        step(1, 0, 3'd1, 0);
        n_checks++;
        if (w_obs !== 10'd0) begin
            n_err++; $display("FAIL enable_off got=%b want=%b", w_obs, 10'd0);
        end
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 3'd1, 0);
            n_checks++;
            if (w_obs !== exp_vec() || ped_green !== 1'b0) begin
                n_err++; $display("FAIL reenable cyc=%0d got=%b want=%b", i, w_obs, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid_walk();
        step(1, 1, 3'd0, 0);
        step(1, 1, 3'd1, 0);
        step(1, 1, 3'd1, 0);
        n_checks++;
        if (w_obs !== exp_vec()) begin
            n_err++; $display("FAIL pre_reset_walk got=%b want=%b", w_obs, exp_vec());
        end
        step(0, 1, 3'd1, 0);
        n_checks++;
        if (w_obs !== 10'd0) begin
            n_err++; $display("FAIL reset_mid_walk got=%b want=%b", w_obs, 10'd0);
        end
    endtask

    task automatic test_random();
        logic [2:0] c = 3'd0;
        bit e, r, q;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0)
                c = ($urandom_range(0, 1) == 1) ? 3'd1 : 3'($urandom_range(0, 7));
            e = ($urandom_range(0, 63) != 0);
            r = ($urandom_range(0, 199) != 0);
            q = ($urandom_range(0, 3) == 0);
            step(r, e, c, q);
            n_checks++;
            if (w_obs !== exp_vec()) begin
                n_err++; $display("FAIL random cyc=%0d got=%b want=%b", i, w_obs, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_walk_sequence();
        test_wait_latch();
        test_abort();
        test_enable_drop();
        test_reset_mid_walk();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
